// File: rtl/port_intr_ctrl_if.sv
// Port/interrupt bus between the processor-facing device logic and its
// surroundings: external producer/consumer, processor I/O ports, interrupt line.
// slave  : the port_intr_ctrl device side.
// master : whatever drives the device (processor, producer, consumer).
interface port_intr_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             ext_in_valid;
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_ready;
    logic [WIDTH-1:0] proc_in_port;
    logic             proc_in_empty;
    logic             proc_in_rd;
    logic             proc_out_wr;
    logic [WIDTH-1:0] proc_out_data;
    logic             ext_out_valid;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_ready;
    logic             ext_irq;
    logic             intr;
    logic             intr_ack;
    logic             proc_rti;
    logic [1:0]       err;

    modport slave (
        input  ext_in_valid, ext_in_data, proc_in_rd, proc_out_wr, proc_out_data,
               ext_out_ready, ext_irq, intr_ack, proc_rti,
        output ext_in_ready, proc_in_port, proc_in_empty, ext_out_valid,
               ext_out_data, intr, err
    );

    modport master (
        output ext_in_valid, ext_in_data, proc_in_rd, proc_out_wr, proc_out_data,
               ext_out_ready, ext_irq, intr_ack, proc_rti,
        input  ext_in_ready, proc_in_port, proc_in_empty, ext_out_valid,
               ext_out_data, intr, err
    );
endinterface

// File: rtl/port_intr_ctrl.sv
// Device-side responder for the processor I/O ports and interrupt line.
// Input FIFO (producer -> processor inputPort), output FIFO (processor
// outputPort -> consumer), and an IDLE/REQ/SERVICE interrupt handshake.
// Optional build macro PORT_IRQ_ON_DATA_EN: when defined, the input FIFO going
// from empty to non-empty raises an interrupt request just like ext_irq.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no interrupt outstanding; leaves on pending request
// ST_REQ     | intr asserted, waiting for intr_ack
// ST_SERVICE | processor in handler, waiting for proc_rti
module port_intr_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    port_intr_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_in_mem  [DEPTH];
    logic [WIDTH-1:0] r_out_mem [DEPTH];
    logic [PW-1:0]    r_in_wp, r_in_rp;
    logic [PW-1:0]    r_out_wp, r_out_rp;
    logic [1:0]       r_err;
    logic             r_pending;
    state_t           r_state, w_state_nxt;

    logic w_in_empty, w_in_full, w_in_push, w_in_pop, w_in_uflow;
    logic w_out_empty, w_out_full, w_out_push, w_out_pop, w_out_oflow;
    logic w_irq_src, w_intr;

    assign w_in_empty  = (r_in_wp == r_in_rp);
    assign w_in_full   = (r_in_wp[PW-1] != r_in_rp[PW-1]) &&
                         (r_in_wp[AW-1:0] == r_in_rp[AW-1:0]);
    // Full is judged on registered state, so a same-cycle pop does not open a slot.
    assign w_in_push   = bus.ext_in_valid & ~w_in_full;
    assign w_in_pop    = bus.proc_in_rd & ~w_in_empty;
    assign w_in_uflow  = bus.proc_in_rd & w_in_empty;

    assign w_out_empty = (r_out_wp == r_out_rp);
    assign w_out_full  = (r_out_wp[PW-1] != r_out_rp[PW-1]) &&
                         (r_out_wp[AW-1:0] == r_out_rp[AW-1:0]);
    assign w_out_pop   = ~w_out_empty & bus.ext_out_ready;
    // A pop in the same cycle frees the slot, so the write is kept even when full.
    assign w_out_push  = bus.proc_out_wr & (~w_out_full | w_out_pop);
    assign w_out_oflow = bus.proc_out_wr & w_out_full & ~w_out_pop;

`ifdef PORT_IRQ_ON_DATA_EN
    assign w_irq_src = bus.ext_irq | (w_in_push & w_in_empty);
`else
    assign w_irq_src = bus.ext_irq;
`endif

    // FIFO storage: data only, no reset needed since heads are masked when empty
    always_ff @(posedge clk) begin
        if (w_in_push)  r_in_mem[r_in_wp[AW-1:0]]   <= bus.ext_in_data;
        if (w_out_push) r_out_mem[r_out_wp[AW-1:0]] <= bus.proc_out_data;
    end

    // FIFO pointers and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_out_wp <= '0;
            r_out_rp <= '0;
            r_err    <= 2'b00;
        end else begin
            if (w_in_push)   r_in_wp  <= r_in_wp + 1'b1;
            if (w_in_pop)    r_in_rp  <= r_in_rp + 1'b1;
            if (w_out_push)  r_out_wp <= r_out_wp + 1'b1;
            if (w_out_pop)   r_out_rp <= r_out_rp + 1'b1;
            if (w_in_uflow)  r_err[0] <= 1'b1;
            if (w_out_oflow) r_err[1] <= 1'b1;
        end
    end

    // Pending request: held until acknowledged; new requests ignored while in REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (r_state == ST_REQ && bus.intr_ack) begin
            r_pending <= 1'b0;
        end else if (w_irq_src && r_state != ST_REQ) begin
            r_pending <= 1'b1;
        end
    end

    // Interrupt FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Interrupt FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (r_pending)    w_state_nxt = ST_REQ;
            ST_REQ:     if (bus.intr_ack) w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (bus.proc_rti) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Interrupt FSM outputs, decoded from state only
    always_comb begin
        w_intr = 1'b0;
        if (r_state == ST_REQ) w_intr = 1'b1;
    end

    assign bus.intr          = w_intr;
    assign bus.ext_in_ready  = ~w_in_full;
    assign bus.proc_in_empty = w_in_empty;
    assign bus.proc_in_port  = w_in_empty ? '0 : r_in_mem[r_in_rp[AW-1:0]];
    assign bus.ext_out_valid = ~w_out_empty;
    assign bus.ext_out_data  = w_out_empty ? '0 : r_out_mem[r_out_rp[AW-1:0]];
    assign bus.err           = r_err;
endmodule

// File: doc/port_intr_ctrl.md
# port_intr_ctrl

Device-side responder for the processor's I/O ports and interrupt line. It sits outside the processor at the other end of the `inputPort`/`outputPort`/`interrupt` interface. It buffers words from an external producer into an input FIFO that drives the processor's input port, and captures words the processor writes to its output port into an output FIFO drained by an external consumer. It also arbitrates external interrupt requests into a request/acknowledge/return-from-interrupt handshake with the processor.

## Interface
Parameters:
- `WIDTH`, 16, port data width.
- `DEPTH`, 4, entries per FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ext_in_valid`  in  1  external producer has a word.
- `ext_in_data`  in  WIDTH  producer word.
- `ext_in_ready`  out  1  input FIFO can accept.
- `proc_in_port`  out  WIDTH  head of input FIFO, to processor `inputPort`.
- `proc_in_empty`  out  1  input FIFO empty.
- `proc_in_rd`  in  1  one-cycle pulse: processor consumed `proc_in_port`.
- `proc_out_wr`  in  1  one-cycle pulse: processor wrote its output port.
- `proc_out_data`  in  WIDTH  value of processor `outputPort`.
- `ext_out_valid`  out  1  output FIFO non-empty.
- `ext_out_data`  out  WIDTH  output FIFO head.
- `ext_out_ready`  in  1  external consumer accepts head.
- `ext_irq`  in  1  external interrupt request, sampled each cycle (level or pulse).
- `intr`  out  1  interrupt to processor.
- `intr_ack`  in  1  processor accepted interrupt (one-cycle pulse).
- `proc_rti`  in  1  processor executed RTI (one-cycle pulse).
- `err`  out  2  sticky: [0] input underflow, [1] output overflow.

## Operation
- Input FIFO:
  - Push on `ext_in_valid & ext_in_ready`.
  - Pop on `proc_in_rd & !proc_in_empty`.
  - `ext_in_ready = !full`. Full is evaluated before a same-cycle pop, so there is no push when full even if a pop occurs.
  - Pop when empty is ignored and sets `err[0]`.
- Output FIFO:
  - Push on `proc_out_wr`. When full, the word is dropped, FIFO state is unchanged, and `err[1]` is set.
  - Pop on `ext_out_valid & ext_out_ready`.
  - When full, a same-cycle pop and push both occur; the count is unchanged and nothing is dropped.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Empty when the pointers are equal; full when the MSBs differ and the LSBs are equal.
- `proc_in_port` and `ext_out_data` are the FIFO head when non-empty, and 0 when empty.
- Interrupt FSM:
  - IDLE: `intr`=0. `pending` → REQ.
  - REQ: `intr`=1. `intr_ack` → SERVICE and clear `pending`.
  - SERVICE: `intr`=0. `proc_rti` → IDLE.
  - `pending` sets on any cycle with `ext_irq`=1 outside REQ. It stays set until the next ack, so a request during SERVICE causes a re-entry to REQ after RTI.
  - `intr_ack` outside REQ and `proc_rti` outside SERVICE are ignored.
- `err` bits clear only on reset.

## Timing
- Reset (async, `rst_n`=0) forces:
  - both FIFOs empty;
  - `ext_in_ready`=1, `proc_in_empty`=1, `proc_in_port`=0;
  - `ext_out_valid`=0, `ext_out_data`=0;
  - FSM=IDLE, `intr`=0, `pending`=0, `err`=0.
- Reset mid-handshake aborts the handshake; FIFO contents are lost.
- Input path latency: a word pushed at edge N is visible on `proc_in_port` after edge N (one cycle from `ext_in_valid` to availability). After a pop at edge N, the next entry is visible after edge N.
- Output path latency: a write at edge N gives `ext_out_valid`=1 after edge N.
- Interrupt latency: `ext_irq` sampled at edge N sets `pending`; FSM enters REQ at edge N+1, so `intr` rises two edges after `ext_irq` is sampled. `intr` falls after the edge that samples `intr_ack`.
- `intr`, `ext_in_ready`, `proc_in_empty` and `ext_out_valid` are decoded from registers only; there is no combinational path from inputs.

## Configuration
- `PORT_IRQ_ON_DATA_EN`:
  - Defined: an input-FIFO transition from empty to non-empty also sets `pending`, as if `ext_irq` were pulsed that cycle.
  - Undefined: interrupts come only from `ext_irq`, and this logic is absent.

## Test plan
- Reset, DEPTH=4:
  - push 0x1111, 0x2222, 0x3333, 0x4444 → `ext_in_ready`=0 after the 4th;
  - `proc_in_port`=0x1111; pop 4 times → 0x2222, 0x3333, 0x4444 in order, then `proc_in_empty`=1.
- Input underflow: `proc_in_rd` on an empty FIFO → `err`=2'b01, `proc_in_port` stays 0. Output overflow: with `ext_out_ready`=0, five `proc_out_wr` pulses of 0xA0–0xA4 → `err`=2'b11 and drained data is 0xA0–0xA3.
- Output full with simultaneous `proc_out_wr`=0xBEEF and `ext_out_ready`=1 → head pops, 0xBEEF is enqueued, `err[1]` unchanged.
- `ext_irq` pulse → `intr`=1 two edges later; `intr_ack` → `intr`=0; `ext_irq` again during SERVICE → no `intr` until `proc_rti`, then `intr`=1 two edges after RTI.
- Assert `rst_n`=0 while in REQ with 2 words queued → immediately `intr`=0, `proc_in_empty`=1, `err`=0.
- With `PORT_IRQ_ON_DATA_EN`: push 0x0055 into the empty input FIFO → `intr`=1 and `proc_in_port`=0x0055. Without the macro → `intr` stays 0.
